// File: rtl/decl_stream_check.sv
// Purpose : byte-serial recogniser for C-style declarations "TYPE id (, id)* ;" with per-statement status.
// Latency : decl_ok/decl_err are registered and pulse for one cycle directly after the edge that consumes ';'.
// Backpressure: none upstream; in_valid=0 freezes all state and held outputs (pulses still drop).
// Optional: define DECL_CHAR_EN to add "char" as a second type keyword (type_id=1) and reserved word.
module decl_stream_check #(
   parameter int MAX_ID_LEN = 31,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in,
   output logic             decl_ok,
   output logic             decl_err,
   output logic [CNT_W-1:0] var_cnt,
   output logic             type_id
);

`ifdef DECL_CHAR_EN
   localparam logic CHAR_EN = 1'b1;
`else
   localparam logic CHAR_EN = 1'b0;
`endif

   localparam logic [7:0] MAX_LEN8 = 8'(MAX_ID_LEN);
   localparam logic [7:0] CH_SEMI  = 8'h3B;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_I     = 8'h69;
   localparam logic [7:0] CH_C     = 8'h63;

   typedef enum logic [2:0] {
      S_IDLE, S_KW, S_PRE_ID, S_ID, S_POST_ID, S_ERR
   } state_t;

   function automatic logic f_ws(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
   endfunction

   function automatic logic f_let(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h5F);
   endfunction

   function automatic logic f_dig(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Keyword spelling: cand 0 = "int", cand 1 = "char".
   function automatic logic [7:0] f_kw_byte(input logic cand, input logic [2:0] idx);
      logic [7:0] b;
      case ({cand, idx})
         4'b0_000: b = 8'h69;
         4'b0_001: b = 8'h6E;
         4'b0_010: b = 8'h74;
         4'b1_000: b = 8'h63;
         4'b1_001: b = 8'h68;
         4'b1_010: b = 8'h61;
         4'b1_011: b = 8'h72;
         default:  b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [2:0] f_kw_len(input logic cand);
      return cand ? 3'd4 : 3'd3;
   endfunction

   state_t           r_state,   w_state_nxt;
   logic             r_cand,    w_cand_nxt;     // keyword candidate being spelled
   logic [2:0]       r_idx,     w_idx_nxt;      // chars of the keyword matched so far
   logic [7:0]       r_len,     w_len_nxt;      // current identifier length
   logic             r_mi,      w_mi_nxt;       // identifier still a prefix of "int"
   logic             r_mc,      w_mc_nxt;       // identifier still a prefix of "char"
   logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;      // identifiers completed in this statement
   logic             r_type,    w_type_nxt;     // type latched after the keyword
   logic             r_ok,      w_ok_nxt;
   logic             r_err,     w_err_nxt;
   logic [CNT_W-1:0] r_var_cnt, w_var_cnt_nxt;
   logic             r_type_id, w_type_id_nxt;

   logic             w_ws, w_let, w_dig, w_semi, w_comma;
   logic             w_id_kw;
   logic [CNT_W-1:0] w_cnt_inc;

   assign w_ws    = f_ws(in);
   assign w_let   = f_let(in);
   assign w_dig   = f_dig(in);
   assign w_semi  = (in == CH_SEMI);
   assign w_comma = (in == CH_COMMA);

   // An identifier is reserved only when its whole text equals an enabled keyword.
   assign w_id_kw   = ((r_len == 8'd3) && r_mi) || (CHAR_EN && (r_len == 8'd4) && r_mc);
   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

   // Next-state and next-output decode; everything holds unless a character is consumed.
   always_comb begin
      w_state_nxt   = r_state;
      w_cand_nxt    = r_cand;
      w_idx_nxt     = r_idx;
      w_len_nxt     = r_len;
      w_mi_nxt      = r_mi;
      w_mc_nxt      = r_mc;
      w_cnt_nxt     = r_cnt;
      w_type_nxt    = r_type;
      w_ok_nxt      = 1'b0;
      w_err_nxt     = 1'b0;
      w_var_cnt_nxt = r_var_cnt;
      w_type_id_nxt = r_type_id;
      if (in_valid) begin
         case (r_state)
            S_IDLE: begin
               if (w_ws || w_semi) begin
                  w_state_nxt = S_IDLE;
               end else if (in == CH_I) begin
                  w_state_nxt = S_KW;
                  w_cand_nxt  = 1'b0;
                  w_idx_nxt   = 3'd1;
               end else if (CHAR_EN && (in == CH_C)) begin
                  w_state_nxt = S_KW;
                  w_cand_nxt  = 1'b1;
                  w_idx_nxt   = 3'd1;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
            S_KW: begin
               if (r_idx == f_kw_len(r_cand)) begin
                  if (w_ws) begin
                     w_state_nxt = S_PRE_ID;
                     w_type_nxt  = r_cand;
                     w_cnt_nxt   = '0;
                  end else if (w_semi) begin
                     w_state_nxt = S_IDLE;
                     w_err_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = S_ERR;
                  end
               end else if (in == f_kw_byte(r_cand, r_idx)) begin
                  w_idx_nxt = r_idx + 3'd1;
               end else if (w_semi) begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
            S_PRE_ID: begin
               if (w_ws) begin
                  w_state_nxt = S_PRE_ID;
               end else if (w_let) begin
                  w_state_nxt = S_ID;
                  w_len_nxt   = 8'd1;
                  w_mi_nxt    = (in == CH_I);
                  w_mc_nxt    = (in == CH_C);
               end else if (w_semi) begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
            S_ID: begin
               if (w_let || w_dig) begin
                  if (r_len == MAX_LEN8) begin
                     w_state_nxt = S_ERR;
                  end else begin
                     w_len_nxt = r_len + 8'd1;
                     w_mi_nxt  = r_mi && (r_len < 8'd3) && (in == f_kw_byte(1'b0, r_len[2:0]));
                     w_mc_nxt  = r_mc && (r_len < 8'd4) && (in == f_kw_byte(1'b1, r_len[2:0]));
                  end
               end else if (w_ws || w_comma) begin
                  if (w_id_kw) begin
                     w_state_nxt = S_ERR;
                  end else begin
                     w_state_nxt = w_ws ? S_POST_ID : S_PRE_ID;
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else if (w_semi) begin
                  w_state_nxt = S_IDLE;
                  if (w_id_kw) begin
                     w_err_nxt = 1'b1;
                  end else begin
                     w_ok_nxt      = 1'b1;
                     w_var_cnt_nxt = w_cnt_inc;
                     w_type_id_nxt = r_type;
                  end
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
            S_POST_ID: begin
               if (w_ws) begin
                  w_state_nxt = S_POST_ID;
               end else if (w_comma) begin
                  w_state_nxt = S_PRE_ID;
               end else if (w_semi) begin
                  w_state_nxt   = S_IDLE;
                  w_ok_nxt      = 1'b1;
                  w_var_cnt_nxt = r_cnt;
                  w_type_id_nxt = r_type;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
            S_ERR: begin
               if (w_semi) begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers; synchronous reset discards any partial statement.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cand    <= 1'b0;
         r_idx     <= 3'd0;
         r_len     <= 8'd0;
         r_mi      <= 1'b0;
         r_mc      <= 1'b0;
         r_cnt     <= '0;
         r_type    <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_var_cnt <= '0;
         r_type_id <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cand    <= w_cand_nxt;
         r_idx     <= w_idx_nxt;
         r_len     <= w_len_nxt;
         r_mi      <= w_mi_nxt;
         r_mc      <= w_mc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_type    <= w_type_nxt;
         r_ok      <= w_ok_nxt;
         r_err     <= w_err_nxt;
         r_var_cnt <= w_var_cnt_nxt;
         r_type_id <= w_type_id_nxt;
      end
   end

   assign decl_ok  = r_ok;
   assign decl_err = r_err;
   assign var_cnt  = r_var_cnt;
   assign type_id  = r_type_id;

endmodule

// File: tb/tb_decl_stream_check.sv
// Purpose : directed bench for decl_stream_check with MAX_ID_LEN=4, CNT_W=2.
// Latency : expects each pulse visible right after the ';' edge and gone one edge later.
// Backpressure: stall cycles present ';' with in_valid=0 to show unconsumed bytes are ignored.
module tb_decl_stream_check;

   localparam int MAX_ID_LEN = 4;
   localparam int CNT_W      = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [7:0]       in_ch;
   logic             decl_ok;
   logic             decl_err;
   logic [CNT_W-1:0] var_cnt;
   logic             type_id;

   int checks   = 0;
   int failures = 0;
   int n_ok;
   int n_err;

   decl_stream_check #(
      .MAX_ID_LEN (MAX_ID_LEN),
      .CNT_W      (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in       (in_ch),
      .decl_ok  (decl_ok),
      .decl_err (decl_err),
      .var_cnt  (var_cnt),
      .type_id  (type_id)
   );

   always #5 clk = ~clk;

   // One clock edge, then sample 1 time unit later and tally any pulses seen.
   task automatic tick();
      @(posedge clk);
      #1;
      if (decl_ok === 1'b1) n_ok++;
      if (decl_err === 1'b1) n_err++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send_raw(input string s);
      for (int i = 0; i < s.len(); i++) begin
         in_valid = 1'b1;
         in_ch    = s[i];
         tick();
      end
   endtask

   // Stream a statement, then check pulse timing, pulse counts and held outputs.
   task automatic run_stmt(input string tag, input string s, input bit stall,
                           input int exp_ok, input int exp_err, input int exp_cnt, input int exp_type);
      logic lat_ok;
      logic lat_err;
      n_ok  = 0;
      n_err = 0;
      for (int i = 0; i < s.len(); i++) begin
         if (stall) begin
            in_valid = 1'b0;
            in_ch    = 8'h3B;
            tick();
         end
         in_valid = 1'b1;
         in_ch    = s[i];
         tick();
      end
      lat_ok   = decl_ok;
      lat_err  = decl_err;
      in_valid = 1'b0;
      in_ch    = 8'h3B;
      tick();
      chk({tag, "_lat_ok"}, 32'(lat_ok), 32'(exp_ok != 0));
      chk({tag, "_lat_err"}, 32'(lat_err), 32'(exp_err != 0));
      chk({tag, "_drop"}, 32'({decl_ok, decl_err}), 32'd0);
      chk({tag, "_n_ok"}, n_ok, exp_ok);
      chk({tag, "_n_err"}, n_err, exp_err);
      if (exp_ok != 0) begin
         chk({tag, "_var_cnt"}, 32'(var_cnt), exp_cnt);
         chk({tag, "_type_id"}, 32'(type_id), exp_type);
      end
   endtask

   string errs [4];

   initial begin
      errs[0] = "int int;";
      errs[1] = "int 1a;";
      errs[2] = "int a b;";
      errs[3] = "float q;";

      reset    = 1'b1;
      in_valid = 1'b0;
      in_ch    = 8'h00;
      tick();
      tick();
      chk("rst_ok", 32'(decl_ok), 32'd0);
      chk("rst_err", 32'(decl_err), 32'd0);
      chk("rst_cnt", 32'(var_cnt), 32'd0);
      chk("rst_type", 32'(type_id), 32'd0);
      reset = 1'b0;
      tick();

      run_stmt("basic", "int a;", 1'b0, 1, 0, 1, 0);
      run_stmt("list_stall", " int\tx1 , _y,z ;", 1'b1, 1, 0, 3, 0);

      for (int i = 0; i < 4; i++) begin
         run_stmt($sformatf("err%0d", i), errs[i], 1'b0, 0, 1, 0, 0);
         run_stmt($sformatf("recover%0d", i), "int k;", 1'b0, 1, 0, 1, 0);
      end

      run_stmt("len_max", "int abcd;", 1'b0, 1, 0, 1, 0);
      run_stmt("len_over", "int abcde;", 1'b0, 0, 1, 0, 0);
      run_stmt("cnt_sat", "int a,b,c,d,e;", 1'b0, 1, 0, 3, 0);
      run_stmt("back2back", "int a;int b;", 1'b0, 2, 0, 1, 0);
      run_stmt("pre_rst", "int a,b;", 1'b0, 1, 0, 2, 0);

      // Reset mid-statement with ';' offered: reset must win and clear outputs.
      send_raw("int ab");
      reset    = 1'b1;
      in_valid = 1'b1;
      in_ch    = 8'h3B;
      n_ok     = 0;
      n_err    = 0;
      tick();
      chk("midrst_ok", 32'(decl_ok), 32'd0);
      chk("midrst_err", 32'(decl_err), 32'd0);
      chk("midrst_cnt", 32'(var_cnt), 32'd0);
      chk("midrst_type", 32'(type_id), 32'd0);
      tick();
      chk("midrst_pulses", n_ok + n_err, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      run_stmt("after_rst", "c;", 1'b0, 0, 1, 0, 0);
      run_stmt("empty", ";;", 1'b0, 0, 0, 0, 0);

`ifdef DECL_CHAR_EN
      run_stmt("char_ok", "char c;", 1'b0, 1, 0, 1, 1);
      run_stmt("int_after_char", "int k;", 1'b0, 1, 0, 1, 0);
      run_stmt("char_reserved", "int char;", 1'b0, 0, 1, 0, 0);
`else
      run_stmt("char_type_off", "char c;", 1'b0, 0, 1, 0, 0);
      run_stmt("char_ident", "int char;", 1'b0, 1, 0, 1, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
